// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int MDU_ITER = 32;
    localparam logic [MDU_ITER-1:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        OP_MULU = 2'b00,
        OP_MUL  = 2'b01,
        OP_DIVU = 2'b10,
        OP_DIV  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// Issue-side request / result bundle between the pipeline and the MDU.
interface mdu_if
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_ITER
);

    logic                  start;
    mdu_op_e               op;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  abort;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic                  div_by_zero;

    modport master (
        output start, op, src_a, src_b, abort,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, src_a, src_b, abort,
        output busy, done, hi, lo, div_by_zero
    );

endinterface

// File: rtl/mdu_negate.sv
// Conditional two's-complement negation, used for magnitudes and result fix-up.
module mdu_negate #(
    parameter int WIDTH = 32
) (
    input  logic             en,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] result
);

    assign result = en ? ('0 - value) : value;

endmodule

// File: rtl/mdu_iterative.sv
// Iterative shift-add multiplier / restoring divider for the execute stage.
// Define MDU_EARLY_OUT_EN to let multiplies finish once the multiplier runs out of set bits.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_ITER,
    parameter int CNT_WIDTH  = 6
) (
    input  logic clk,
    input  logic rst,
    mdu_if.slave bus
);

    localparam int W  = DATA_WIDTH;
    localparam int W2 = 2 * DATA_WIDTH;

    mdu_state_e     state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [W2-1:0]  acc;
    logic [W2-1:0]  opa;
    logic [W-1:0]   opb;
    logic           div_r;
    logic           neg_p;
    logic           neg_r;
    logic           dbz_r;

    logic           busy_q;
    logic           done_q;
    logic           dbz_q;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;

    logic           is_div;
    logic           is_sgn;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W2-1:0]  prod_fix;
    logic [W-1:0]   quot_fix;
    logic [W-1:0]   rem_fix;
    logic [W2-1:0]  res;
    logic [W:0]     trial;
    logic           mul_idle;

    assign is_div = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
    assign is_sgn = (bus.op == OP_MUL) || (bus.op == OP_DIV);
    assign a_neg  = is_sgn & bus.src_a[W-1];
    assign b_neg  = is_sgn & bus.src_b[W-1];

    mdu_negate #(.WIDTH(W)) u_mag_a (
        .en(a_neg), .value(bus.src_a), .result(mag_a)
    );

    mdu_negate #(.WIDTH(W)) u_mag_b (
        .en(b_neg), .value(bus.src_b), .result(mag_b)
    );

    mdu_negate #(.WIDTH(W2)) u_fix_prod (
        .en(neg_p), .value(acc), .result(prod_fix)
    );

    mdu_negate #(.WIDTH(W)) u_fix_quot (
        .en(neg_p), .value(acc[W-1:0]), .result(quot_fix)
    );

    mdu_negate #(.WIDTH(W)) u_fix_rem (
        .en(neg_r), .value(acc[W2-1:W]), .result(rem_fix)
    );

    // Divide keeps {remainder, dividend/quotient} in acc; the trial is the
    // partial remainder with the next dividend bit shifted in.
    always_comb begin
        trial = {acc[W2-1:W], acc[W-1]} - {1'b0, opb};
        res   = div_r ? {rem_fix, quot_fix} : prod_fix;
    end

`ifdef MDU_EARLY_OUT_EN
    assign mul_idle = !div_r && (opb == '0);
`else
    assign mul_idle = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            div_r  <= 1'b0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            dbz_r  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        div_r  <= is_div;
                        cnt    <= CNT_WIDTH'(DATA_WIDTH);
                        opa    <= {{W{1'b0}}, mag_a};
                        opb    <= mag_b;
                        if (is_div && bus.src_b == '0) begin
                            // Preload the fixed result and skip the iterations
                            acc   <= {bus.src_a, {W{DIV0_QUOT[0]}}};
                            neg_p <= 1'b0;
                            neg_r <= 1'b0;
                            dbz_r <= 1'b1;
                            state <= S_FIX;
                        end else begin
                            acc   <= is_div ? {{W{1'b0}}, mag_a} : '0;
                            neg_p <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            dbz_r <= 1'b0;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.abort) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else if (mul_idle) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_WIDTH'(1)) state <= S_FIX;
                        if (div_r) begin
                            acc <= trial[W] ? {acc[W2-2:0], 1'b0}
                                            : {trial[W-1:0], acc[W-2:0], 1'b1};
                        end else begin
                            if (opb[0]) acc <= acc + opa;
                            opa <= opa << 1;
                            opb <= opb >> 1;
                        end
                    end
                end
                S_FIX: begin
                    if (bus.abort) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        hi_q   <= res[W2-1:W];
                        lo_q   <= res[W-1:0];
                        dbz_q  <= dbz_r;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative.
module tb_mdu_iterative;
    import mdu_pkg::*;

`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk;
    logic rst;
    int checks;
    int failures;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    mdu_if #(.DATA_WIDTH(32)) bus ();

    mdu_iterative #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mul_lat(input logic [31:0] mag);
        int k;
        k = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
        return EARLY ? k + 3 : 34;
    endfunction

    task automatic run(input string tag, input mdu_op_e op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input logic exp_dbz, input int exp_lat,
                       input int intrude_at);
        int cyc;
        int busy_bad;
        bus.op = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        busy_bad = 0;
        while (!bus.done && cyc < 200) begin
            if (bus.busy !== 1'b1) busy_bad++;
            if (cyc == intrude_at) begin
                bus.op = OP_DIVU;
                bus.src_a = 32'd9;
                bus.src_b = 32'd3;
                bus.start = 1'b1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
        end
        chk($sformatf("%s latency", tag), 64'(cyc), 64'(exp_lat));
        chk($sformatf("%s busy_low_cycles", tag), 64'(busy_bad), 64'd0);
        chk($sformatf("%s busy_at_done", tag), 64'(bus.busy), 64'd0);
        chk($sformatf("%s hi", tag), 64'(bus.hi), 64'(exp_hi));
        chk($sformatf("%s lo", tag), 64'(bus.lo), 64'(exp_lo));
        chk($sformatf("%s dbz", tag), 64'(bus.div_by_zero), 64'(exp_dbz));
        // start during the DONE cycle must be dropped
        bus.op = OP_MULU;
        bus.src_a = 32'd3;
        bus.src_b = 32'd3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk($sformatf("%s done_start_dropped", tag),
            64'({bus.done, bus.busy}), 64'd0);
        last_hi = exp_hi;
        last_lo = exp_lo;
    endtask

    task automatic abort_run(input string tag, input int abort_at,
                             input logic with_start);
        int cyc;
        int stray;
        bus.op = OP_DIVU;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < abort_at) begin
            @(posedge clk); #1;
            cyc++;
        end
        bus.abort = 1'b1;
        if (with_start) begin
            bus.op = OP_MULU;
            bus.src_a = 32'd5;
            bus.src_b = 32'd5;
            bus.start = 1'b1;
        end
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk($sformatf("%s busy_after_abort", tag), 64'(bus.busy), 64'd0);
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        chk($sformatf("%s no_done_or_busy", tag), 64'(stray), 64'd0);
        chk($sformatf("%s hi_kept", tag), 64'(bus.hi), 64'(last_hi));
        chk($sformatf("%s lo_kept", tag), 64'(bus.lo), 64'(last_lo));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        last_hi = '0;
        last_lo = '0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.op = OP_MULU;
        bus.src_a = '0;
        bus.src_b = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("reset ctrl", 64'({bus.busy, bus.done, bus.div_by_zero}), 64'd0);
        chk("reset hi", 64'(bus.hi), 64'd0);
        chk("reset lo", 64'(bus.lo), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        run("mulu_max", OP_MULU, 32'hFFFFFFFF, 32'd2,
            32'h00000001, 32'hFFFFFFFE, 1'b0, mul_lat(32'd2), 0);
        run("mul_neg", OP_MUL, 32'hFFFFFFFD, 32'd7,
            32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, mul_lat(32'd7), 0);
        run("mul_nn", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h0, 32'h1, 1'b0, mul_lat(32'd1), 0);
        run("mulu_small", OP_MULU, 32'd5, 32'd3,
            32'h0, 32'd15, 1'b0, mul_lat(32'd3), 0);
        run("mulu_zero", OP_MULU, 32'd12345, 32'd0,
            32'h0, 32'h0, 1'b0, mul_lat(32'd0), 0);
        run("div_neg_a", OP_DIV, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 0);
        run("div_neg_b", OP_DIV, 32'd7, 32'hFFFFFFFE,
            32'h1, 32'hFFFFFFFD, 1'b0, 34, 0);
        run("divu_zero", OP_DIVU, 32'd100, 32'd0,
            32'd100, 32'hFFFFFFFF, 1'b1, 2, 0);
        run("divu", OP_DIVU, 32'd100, 32'd7,
            32'd2, 32'd14, 1'b0, 34, 0);
        run("div_zero_s", OP_DIV, 32'hFFFFFFF9, 32'd0,
            32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2, 0);
        run("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF,
            32'h0, 32'h80000000, 1'b0, 34, 0);
        run("busy_start", OP_MULU, 32'd6, 32'd7,
            32'h0, 32'd42, 1'b0, mul_lat(32'd7), 3);

        abort_run("abort", 10, 1'b0);
        abort_run("abort_start", 5, 1'b1);

        bus.op = OP_DIVU;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        chk("midrst ctrl", 64'({bus.busy, bus.done, bus.div_by_zero}), 64'd0);
        chk("midrst hi", 64'(bus.hi), 64'd0);
        chk("midrst lo", 64'(bus.lo), 64'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        run("after_rst", OP_DIVU, 32'd100, 32'd7,
            32'd2, 32'd14, 1'b0, 34, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
